// File: rtl/scroll_ctrl_if.sv
// Command and display bundle for scroll_ctrl. The controller drives the master side,
// and scroll_ctrl implements the slave side.
interface scroll_ctrl_if;
    logic       clear;
    logic       start;
    logic       stop;
    logic       step;
    logic       dir;
    logic [1:0] speed;
    logic [3:0] base;
    logic [3:0] digit_sel;
    logic [3:0] digit_val;
    logic       running;
    logic       wrap;
    logic [1:0] dbg_state;

    // All command inputs are single-cycle pulses sampled on the rising clock edge.
    // There is no back-pressure: every pulse is either acted on or dropped in that cycle.
    modport master (
        output clear, start, stop, step, dir, speed,
        input  base, digit_sel, digit_val, running, wrap, dbg_state
    );

    modport slave (
        input  clear, start, stop, step, dir, speed,
        output base, digit_sel, digit_val, running, wrap, dbg_state
    );
endinterface

// File: rtl/scroll_ctrl.sv
// Scrolling 4-digit hex window: a run/pause/step FSM moves a modulo-16 base,
// and a refresh scanner multiplexes base..base+3 onto the digits.
module scroll_ctrl #(
    parameter int unsigned TICK_DIV    = 12_500_000,
    parameter int unsigned REFRESH_DIV = 100_000
) (
    input  logic          clk,
    input  logic          rst,
    scroll_ctrl_if.slave  bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int RW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    base_q, base_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          wrap_q, wrap_d;
    logic [RW-1:0] ref_q, ref_d;
    logic [1:0]    idx_q, idx_d;

    logic [PW-1:0] limit;
    logic [3:0]    adv_val;
    logic          adv_wrap;

    // The limit follows speed combinationally. Because the compare is >=,
    // a prescaler already past a lowered limit ticks on the next cycle.
    assign limit    = PW'((TICK_DIV >> bus.speed) - 32'd1);
    assign adv_val  = bus.dir ? (base_q - 4'd1) : (base_q + 4'd1);
    assign adv_wrap = bus.dir ? (base_q == 4'h0) : (base_q == 4'hF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            base_q  <= 4'h0;
            presc_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            presc_q <= presc_d;
            wrap_q  <= wrap_d;
        end
    end

    // The else-if chain sets command priority: a higher-priority pulse
    // blocks the lower ones, even when that higher pulse has no effect.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        presc_d = presc_q;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            base_d  = 4'h0;
            presc_d = '0;
        end else if (bus.stop) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else if (bus.start && (state_q != RUN)) begin
            state_d = RUN;
            presc_d = '0;
        end else if (bus.step && (state_q != RUN)) begin
            base_d = adv_val;
            wrap_d = adv_wrap;
        end else if (state_q == RUN) begin
            if (presc_q >= limit) begin
                presc_d = '0;
                base_d  = adv_val;
                wrap_d  = adv_wrap;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_q <= '0;
            idx_q <= 2'd3;
        end else begin
            ref_q <= ref_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        ref_d = ref_q + RW'(1);
        idx_d = idx_q;
        if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = idx_q - 2'd1;
        end
    end

    // The display is decoded from registered state, so it changes on the same edge as base.
    assign bus.digit_sel = ~(4'b0001 << idx_q);
    assign bus.digit_val = base_q + (4'd3 - {2'b00, idx_q});
    assign bus.base      = base_q;
    assign bus.running   = (state_q == RUN);
    assign bus.wrap      = wrap_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_scroll_ctrl.sv
// Bench for scroll_ctrl with TICK_DIV=16 and REFRESH_DIV=4. It runs a vector table
// plus hand-written sequences for the tick, wrap, speed, display and reset cases.
module tb_scroll_ctrl;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [7:0] exp_q[$];

    scroll_ctrl_if bus_if ();

    scroll_ctrl #(.TICK_DIV(16), .REFRESH_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       clr;
        logic       go;
        logic       halt;
        logic       stp;
        logic       dir;
        logic [1:0] spd;
        logic [1:0] st;
        logic [3:0] b;
        logic       w;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(logic clr, logic go, logic halt, logic stp, logic dir,
                                logic [1:0] st, logic [3:0] b, logic w);
        vec_t v;
        v.clr = clr; v.go = go; v.halt = halt; v.stp = stp; v.dir = dir; v.spd = 2'd0;
        v.st = st; v.b = b; v.w = w;
        return v;
    endfunction

    function automatic logic [7:0] ec(logic [1:0] st, logic [3:0] b, logic w);
        return {st, (st == S_RUN), w, b};
    endfunction

    function automatic logic [7:0] core_now();
        return {bus_if.dbg_state, bus_if.running, bus_if.wrap, bus_if.base};
    endfunction

    function automatic logic [7:0] disp_now();
        return {bus_if.digit_sel, bus_if.digit_val};
    endfunction

    task automatic drive(logic clr, logic go, logic halt, logic stp, logic dir, logic [1:0] spd);
        bus_if.clear = clr;
        bus_if.start = go;
        bus_if.stop  = halt;
        bus_if.step  = stp;
        bus_if.dir   = dir;
        bus_if.speed = spd;
    endtask

    task automatic release_cmds();
        bus_if.clear = 1'b0;
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        bus_if.step  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(logic [7:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(string name, logic [7:0] act);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %h but scoreboard queue empty", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, act, e);
            end
        end
    endtask

    // One commanded cycle: queue the expectation, clock once, compare.
    task automatic cyc_core(string name, logic [7:0] e);
        push_exp(e);
        tick();
        chk(name, core_now());
    endtask

    initial begin
        int n;
        logic [1:0] idx;
        logic [3:0] b;
        logic [3:0] steps[5];

        errors = 0;
        checks = 0;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 2'd0);

        vt[0]  = mk(0, 0, 0, 0, 0, S_IDLE,  4'h0, 0);
        vt[1]  = mk(0, 0, 0, 1, 0, S_IDLE,  4'h1, 0);
        vt[2]  = mk(0, 0, 0, 1, 1, S_IDLE,  4'h0, 0);
        vt[3]  = mk(0, 0, 0, 1, 1, S_IDLE,  4'hF, 1);
        vt[4]  = mk(0, 0, 0, 0, 0, S_IDLE,  4'hF, 0);
        vt[5]  = mk(0, 0, 0, 1, 0, S_IDLE,  4'h0, 1);
        vt[6]  = mk(0, 0, 1, 1, 0, S_IDLE,  4'h0, 0);
        vt[7]  = mk(0, 1, 0, 0, 0, S_RUN,   4'h0, 0);
        vt[8]  = mk(0, 0, 0, 1, 0, S_RUN,   4'h0, 0);
        vt[9]  = mk(0, 1, 0, 0, 0, S_RUN,   4'h0, 0);
        vt[10] = mk(0, 0, 1, 0, 0, S_PAUSE, 4'h0, 0);
        vt[11] = mk(0, 1, 1, 0, 0, S_PAUSE, 4'h0, 0);
        vt[12] = mk(0, 0, 0, 1, 1, S_PAUSE, 4'hF, 1);
        vt[13] = mk(0, 1, 0, 0, 0, S_RUN,   4'hF, 0);
        vt[14] = mk(1, 1, 0, 0, 0, S_IDLE,  4'h0, 0);
        vt[15] = mk(0, 0, 0, 1, 0, S_IDLE,  4'h1, 0);
        vt[16] = mk(1, 0, 0, 1, 0, S_IDLE,  4'h0, 0);

        repeat (2) tick();
        push_exp(ec(S_IDLE, 4'h0, 0));
        chk("reset_core", core_now());
        push_exp({4'b0111, 4'h0});
        chk("reset_disp", disp_now());
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].clr, vt[i].go, vt[i].halt, vt[i].stp, vt[i].dir, vt[i].spd);
            cyc_core($sformatf("vec%0d", i), ec(vt[i].st, vt[i].b, vt[i].w));
        end
        release_cmds();

        drive(0, 1, 0, 0, 0, 2'd0);
        cyc_core("run_entry", ec(S_RUN, 4'h0, 0));
        release_cmds();
        for (int k = 1; k <= 48; k++) begin
            cyc_core($sformatf("run_tick_k%0d", k), ec(S_RUN, 4'(k / 16), 0));
        end

        drive(1, 0, 0, 0, 0, 2'd0);
        cyc_core("up_wrap_clear", ec(S_IDLE, 4'h0, 0));
        drive(0, 0, 0, 1, 1, 2'd0);
        cyc_core("up_wrap_pre", ec(S_IDLE, 4'hF, 1));
        drive(0, 1, 0, 0, 0, 2'd3);
        cyc_core("up_wrap_entry", ec(S_RUN, 4'hF, 0));
        release_cmds();
        cyc_core("up_wrap_e1", ec(S_RUN, 4'hF, 0));
        cyc_core("up_wrap_e2", ec(S_RUN, 4'h0, 1));
        cyc_core("up_wrap_e3", ec(S_RUN, 4'h0, 0));
        bus_if.dir = 1'b1;
        cyc_core("dn_wrap_e4", ec(S_RUN, 4'hF, 1));
        cyc_core("dn_wrap_e5", ec(S_RUN, 4'hF, 0));

        drive(1, 0, 0, 0, 0, 2'd3);
        cyc_core("pause_clear", ec(S_IDLE, 4'h0, 0));
        drive(0, 0, 0, 1, 0, 2'd3);
        cyc_core("pause_up1", ec(S_IDLE, 4'h1, 0));
        cyc_core("pause_up2", ec(S_IDLE, 4'h2, 0));
        drive(0, 1, 0, 0, 0, 2'd3);
        cyc_core("pause_start", ec(S_RUN, 4'h2, 0));
        drive(0, 0, 1, 0, 0, 2'd3);
        cyc_core("pause_stop", ec(S_PAUSE, 4'h2, 0));
        drive(0, 0, 0, 1, 1, 2'd3);
        cyc_core("pause_dn1", ec(S_PAUSE, 4'h1, 0));
        cyc_core("pause_dn2", ec(S_PAUSE, 4'h0, 0));
        cyc_core("pause_dn3", ec(S_PAUSE, 4'hF, 1));
        release_cmds();
        cyc_core("pause_hold", ec(S_PAUSE, 4'hF, 0));

        drive(1, 0, 0, 0, 0, 2'd0);
        cyc_core("spd_clear", ec(S_IDLE, 4'h0, 0));
        drive(0, 1, 0, 0, 0, 2'd0);
        cyc_core("spd_entry", ec(S_RUN, 4'h0, 0));
        release_cmds();
        repeat (10) tick();
        push_exp(ec(S_RUN, 4'h0, 0));
        chk("spd_presc10", core_now());
        bus_if.speed = 2'd3;
        steps[0] = 4'h1; steps[1] = 4'h1; steps[2] = 4'h2; steps[3] = 4'h2; steps[4] = 4'h3;
        for (int k = 0; k < 5; k++) begin
            cyc_core($sformatf("spd_fast%0d", k), ec(S_RUN, steps[k], 0));
        end

        drive(0, 0, 0, 0, 0, 2'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        push_exp({4'b0111, 4'h0});
        chk("disp_n0", disp_now());
        drive(0, 0, 0, 1, 1, 2'd0);
        for (n = 1; n <= 25; n++) begin
            if (n == 3) release_cmds();
            b   = (n == 1) ? 4'hF : 4'hE;
            idx = 2'(3 - (n / 4));
            push_exp({~(4'b0001 << idx), b + 4'((n / 4) % 4)});
            tick();
            chk($sformatf("disp_n%0d", n), disp_now());
        end

        drive(0, 1, 0, 0, 0, 2'd3);
        cyc_core("rst_run_entry", ec(S_RUN, 4'hE, 0));
        release_cmds();
        tick();
        tick();
        tick();
        push_exp(ec(S_RUN, 4'hF, 0));
        chk("rst_run_pre", core_now());
        #2;
        rst = 1'b0;
        #1;
        push_exp(ec(S_IDLE, 4'h0, 0));
        chk("rst_async_core", core_now());
        push_exp({4'b0111, 4'h0});
        chk("rst_async_disp", disp_now());
        drive(0, 1, 0, 1, 0, 2'd3);
        cyc_core("rst_held_cmd", ec(S_IDLE, 4'h0, 0));
        release_cmds();
        rst = 1'b1;
        repeat (20) tick();
        push_exp(ec(S_IDLE, 4'h0, 0));
        chk("rst_stay_idle", core_now());
        drive(0, 1, 0, 0, 0, 2'd3);
        cyc_core("rst_restart", ec(S_RUN, 4'h0, 0));
        release_cmds();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scroll_ctrl.md
SCROLL_CTRL -- requirements
Module: scroll_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 12_500_000, scroll-step period in clk cycles at speed 0; multiple of 8, >= 8.
REQ-002 Parameter REFRESH_DIV, default 100_000, clk cycles each display digit is held; >= 2.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous clear pulse.
REQ-006 start  input  1  run command pulse.
REQ-007 stop  input  1  pause command pulse.
REQ-008 step  input  1  single-advance command pulse.
REQ-009 dir  input  1  0 = count up, 1 = count down.
REQ-010 speed  input  2  rate select; step period = TICK_DIV >> speed cycles.
REQ-011 base  output  4  current scroll window start value.
REQ-012 digit_sel  output  4  active-low one-hot digit enable.
REQ-013 digit_val  output  4  nibble for the enabled digit, fed to the hex-to-segment converter.
REQ-014 running  output  1  high while in RUN.
REQ-015 wrap  output  1  one-cycle pulse on base wrap-around.

Function
REQ-016 FSM states: IDLE, RUN, PAUSE.
REQ-017 Command priority within one cycle: clear > stop > start > step; lower-priority commands in that cycle are ignored.
REQ-018 clear in any state: next cycle base=0, state IDLE, prescaler=0, wrap=0; refresh counter and digit index unaffected.
REQ-019 start in IDLE or PAUSE: state RUN next cycle, prescaler=0; start in RUN ignored.
REQ-020 stop in RUN: state PAUSE next cycle, base held; stop in IDLE/PAUSE ignored.
REQ-021 step in IDLE or PAUSE: base advances by one in direction dir next cycle, state unchanged; step in RUN ignored.
REQ-022 RUN: prescaler increments every cycle; when prescaler >= (TICK_DIV >> speed) - 1, tick: prescaler=0, base advances one in direction dir.
REQ-023 First tick after entering RUN occurs exactly TICK_DIV >> speed cycles after the entry edge.
REQ-024 speed change mid-RUN takes effect immediately; a prescaler already above the new limit ticks on the next cycle, never overruns.
REQ-025 Prescaler holds its value in PAUSE and IDLE; cleared only on entering RUN, on clear, or on reset.
REQ-026 base arithmetic is modulo 16: up 15->0, down 0->15.
REQ-027 wrap pulses high for exactly the cycle following a 15->0 (up) or 0->15 (down) transition, whether by tick or step.
REQ-028 running = 1 iff state is RUN (registered, no combinational path from inputs).
REQ-029 Refresh counter counts 0..REFRESH_DIV-1 continuously in all states; on terminal count digit index decrements 3->2->1->0->3.
REQ-030 digit_sel bit [idx] = 0, all other bits 1.
REQ-031 digit_val = (base + (3 - idx)) mod 16: digit 3 shows base, digit 0 shows base+3.
REQ-032 digit_val tracks base changes in the same cycle base updates; no extra latency.

Reset
REQ-033 rst low asynchronously forces: state IDLE, base=0, prescaler=0, refresh counter=0, idx=3, digit_sel=4'b0111, digit_val=0, running=0, wrap=0.
REQ-034 rst low mid-RUN aborts any pending tick; after release the block stays in IDLE until start.
REQ-035 All commands ignored while rst is low; first edge after release acts on inputs normally.

Verification (TICK_DIV=16, REFRESH_DIV=4)
REQ-036 Reset, then start, dir=0, speed=0 -> running=1 next cycle; base 0->1 exactly 16 cycles after entry, then every 16 cycles.
REQ-037 RUN with base=15, dir=0 -> next tick base=0, wrap high exactly one cycle; dir=1 at base=0 -> base=15, wrap pulse.
REQ-038 In PAUSE, pulse step 3 times with dir=1 from base=2 -> base 1, 0, 15, wrap on 0->15; state stays PAUSE.
REQ-039 Same-cycle start+stop in PAUSE -> stays PAUSE; clear+start in RUN -> IDLE, base=0.
REQ-040 RUN at speed=0, prescaler=10, switch speed to 3 (limit 1) -> tick next cycle, then every 2 cycles.
REQ-041 base=14, free-running refresh -> digit_sel 0111/1011/1101/1110 each held 4 cycles showing E,F,0,1; rst low mid-sequence -> all outputs at REQ-033 values immediately.
